// File: rtl/trivium_pkg.sv
// Shared types and default parameters for the Trivium sequencer slice.
// Holds the state encoding, byte type and the default session geometry.
package trivium_pkg;

  localparam int KEY_BYTES_DEF  = 10;
  localparam int IV_BYTES_DEF   = 10;
  localparam int WARMUP_CYC_DEF = 1152;
  localparam int LEN_W_DEF      = 16;

  typedef logic [7:0] byte_t;
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LOAD_KEY = 3'd1;
  localparam state_t ST_LOAD_IV  = 3'd2;
  localparam state_t ST_WARMUP   = 3'd3;
  localparam state_t ST_RUN      = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

  // Sizes the shared load/warm-up counter for the largest of the three phases.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trivium_seq_cnt.sv
// Loadable down-counter with zero and last-count flags; saturates at zero.
// Clear has priority over load, load over decrement.
module trivium_seq_cnt
  import trivium_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);
  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/trivium_seq_ctrl.sv
// Sequencer: loads key/IV bytes into the Trivium core, times warm-up, then
// gates keystream bytes into the FIFO. Optional byte_cnt_o via TRIV_SEQ_CNT_EN.
module trivium_seq_ctrl
  import trivium_pkg::*;
#(
  parameter int KEY_BYTES  = KEY_BYTES_DEF,
  parameter int IV_BYTES   = IV_BYTES_DEF,
  parameter int WARMUP_CYC = WARMUP_CYC_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] req_len_i,
  input  logic             abort_i,
  input  logic [7:0]       host_din_i,
  input  logic             host_valid_i,
  output logic             host_ready_o,
  output logic [7:0]       core_din_o,
  output logic             core_stb_key_o,
  output logic             core_stb_data_o,
  output logic             core_en_o,
  input  logic             core_wt_sgn_i,
  input  logic             fifo_full_i,
  output logic             fifo_write_o,
  output logic             busy_o,
  output logic             done_o
`ifdef TRIV_SEQ_CNT_EN
  , output logic [31:0]    byte_cnt_o
`endif
);

  localparam int LD_W = $clog2(max3(KEY_BYTES, IV_BYTES, WARMUP_CYC) + 1);

  state_t          state_q, state_d;
  byte_t           core_din_q;
  logic            stb_key_q, stb_data_q, core_en_q, core_en_d;
  logic            accept;
  logic            ld_load, ld_dec, ld_zero, ld_last;
  logic [LD_W-1:0] ld_val;
  logic            rem_load, rem_dec, rem_zero, rem_last;

  trivium_seq_cnt #(.W(LD_W)) u_ld_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (abort_i),
    .load_i     (ld_load),
    .load_val_i (ld_val),
    .dec_i      (ld_dec),
    .zero_o     (ld_zero),
    .last_o     (ld_last)
  );

  trivium_seq_cnt #(.W(LEN_W)) u_rem_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (abort_i),
    .load_i     (rem_load),
    .load_val_i (req_len_i),
    .dec_i      (rem_dec),
    .zero_o     (rem_zero),
    .last_o     (rem_last)
  );

  // abort masks ready so the host never sees a byte taken on the abort cycle
  assign host_ready_o = !abort_i && ((state_q == ST_LOAD_KEY) || (state_q == ST_LOAD_IV));
  assign accept       = host_ready_o && host_valid_i;
  assign fifo_write_o = core_wt_sgn_i && (state_q == ST_RUN) && !fifo_full_i && !rem_zero;

  always_comb begin
    state_d  = state_q;
    ld_load  = 1'b0;
    ld_val   = '0;
    ld_dec   = 1'b0;
    rem_load = 1'b0;
    rem_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && (req_len_i != '0)) begin
          state_d  = ST_LOAD_KEY;
          ld_load  = 1'b1;
          ld_val   = LD_W'(KEY_BYTES);
          rem_load = 1'b1;
        end
      end
      ST_LOAD_KEY: begin
        if (accept) begin
          ld_dec = 1'b1;
          if (ld_last || ld_zero) begin
            state_d = ST_LOAD_IV;
            ld_load = 1'b1;
            ld_val  = LD_W'(IV_BYTES);
          end
        end
      end
      ST_LOAD_IV: begin
        if (accept) begin
          ld_dec = 1'b1;
          if (ld_last || ld_zero) begin
            state_d = ST_WARMUP;
            ld_load = 1'b1;
            ld_val  = LD_W'(WARMUP_CYC);
          end
        end
      end
      ST_WARMUP: begin
        ld_dec = 1'b1;
        if (ld_last || ld_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (fifo_write_o) begin
          rem_dec = 1'b1;
          if (rem_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
    end
  end

  // Core runs through all of warm-up, and in RUN only while the FIFO has room.
  assign core_en_d = (state_d == ST_WARMUP) || ((state_d == ST_RUN) && !fifo_full_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      core_din_q <= '0;
      stb_key_q  <= 1'b0;
      stb_data_q <= 1'b0;
      core_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_key_q  <= accept && (state_q == ST_LOAD_KEY);
      stb_data_q <= accept && (state_q == ST_LOAD_IV);
      core_en_q  <= core_en_d;
      if (accept) begin
        core_din_q <= host_din_i;
      end
    end
  end

  assign core_din_o      = core_din_q;
  assign core_stb_key_o  = stb_key_q;
  assign core_stb_data_o = stb_data_q;
  assign core_en_o       = core_en_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = (state_q == ST_DONE);

`ifdef TRIV_SEQ_CNT_EN
  logic [31:0] byte_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= '0;
    end else if (fifo_write_o) begin
      byte_cnt_q <= byte_cnt_q + 32'd1;
    end
  end

  assign byte_cnt_o = byte_cnt_q;
`endif

endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// Directed self-checking bench for trivium_seq_ctrl; the core model returns a
// keystream byte whenever core_en is high. Checks byte_cnt_o under TRIV_SEQ_CNT_EN.
module tb_trivium_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, host_valid, fifo_full;
  logic [15:0] req_len;
  logic [7:0]  host_din;
  logic        host_ready, stb_key, stb_data, core_en, core_wt_sgn;
  logic        fifo_write, busy, done;
  logic [7:0]  core_din;
`ifdef TRIV_SEQ_CNT_EN
  logic [31:0] byte_cnt;
`endif

  always #5 clk = ~clk;

  assign core_wt_sgn = core_en;

  trivium_seq_ctrl dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .req_len_i       (req_len),
    .abort_i         (abort),
    .host_din_i      (host_din),
    .host_valid_i    (host_valid),
    .host_ready_o    (host_ready),
    .core_din_o      (core_din),
    .core_stb_key_o  (stb_key),
    .core_stb_data_o (stb_data),
    .core_en_o       (core_en),
    .core_wt_sgn_i   (core_wt_sgn),
    .fifo_full_i     (fifo_full),
    .fifo_write_o    (fifo_write),
    .busy_o          (busy),
    .done_o          (done)
`ifdef TRIV_SEQ_CNT_EN
    , .byte_cnt_o    (byte_cnt)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int n_key, n_data, n_wr, n_done, n_warm;
  logic [7:0] key_log [64];
  logic [7:0] data_log [64];

  // Mid-cycle monitor: inputs change 2ns after posedge, so everything is settled here.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stb_key)  begin key_log[n_key & 63] = core_din;   n_key++;  end
      if (stb_data) begin data_log[n_data & 63] = core_din; n_data++; end
      if (fifo_write) n_wr++;
      if (done) n_done++;
      if (core_en && !fifo_write) n_warm++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    n_key = 0; n_data = 0; n_wr = 0; n_done = 0; n_warm = 0;
  endtask

  task automatic start_session(input logic [15:0] len);
    start = 1'b1; req_len = len;
    tick();
    start = 1'b0; req_len = '0;
  endtask

  task automatic host_xfer(input logic [7:0] d, input bit stall);
    int t;
    if (stall) begin
      host_valid = 1'b0;
      tick();
    end
    host_valid = 1'b1; host_din = d;
    #1;
    t = 0;
    while (host_ready !== 1'b1 && t < 50) begin
      tick(); #1; t++;
    end
    if (t >= 50) begin
      total_cnt++;
      $display("FAIL host_ready_timeout: ready=%b want 1", host_ready);
    end
    tick();
  endtask

  task automatic load_all(input logic [7:0] kb, input logic [7:0] ib, input bit stall);
    for (int i = 0; i < 10; i++) host_xfer(kb + 8'(i), stall);
    for (int i = 0; i < 10; i++) host_xfer(ib + 8'(i), 1'b0);
    host_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (n_done == 0 && t < 3000) begin tick(); t++; end
    if (t >= 3000) begin
      total_cnt++;
      $display("FAIL done_timeout: done_count=%0d want 1", n_done);
    end
    tick();
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (n_wr < n && t < 3000) begin tick(); t++; end
    if (t >= 3000) begin
      total_cnt++;
      $display("FAIL write_timeout: writes=%0d want %0d", n_wr, n);
    end
  endtask

  task automatic check_logs(input string tag, input logic [7:0] kb, input logic [7:0] ib);
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (key_log[i] !== kb + 8'(i)) bad++;
      if (data_log[i] !== ib + 8'(i)) bad++;
    end
    total_cnt++;
    if (n_key !== 10) $display("FAIL %s_key_count: got %0d want 10", tag, n_key); else pass_cnt++;
    total_cnt++;
    if (n_data !== 10) $display("FAIL %s_iv_count: got %0d want 10", tag, n_data); else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL %s_din_order: got %0d wrong bytes want 0", tag, bad); else pass_cnt++;
  endtask

  task automatic test_reset();
    tick();
    total_cnt++;
    if ({busy, host_ready, core_en, stb_key, stb_data, fifo_write, done} !== 7'b0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {busy, host_ready, core_en, stb_key, stb_data, fifo_write, done});
    else pass_cnt++;
    total_cnt++;
    if (core_din !== 8'h00) $display("FAIL reset_core_din: got %h want 00", core_din); else pass_cnt++;
`ifdef TRIV_SEQ_CNT_EN
    total_cnt++;
    if (byte_cnt !== 32'd0) $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_nominal();
    clear_mon();
    start_session(16'd4);
    total_cnt++;
    if (host_ready !== 1'b1) $display("FAIL nom_ready: got %b want 1", host_ready); else pass_cnt++;
    load_all(8'h00, 8'hA0, 1'b0);
    wait_done();
    check_logs("nom", 8'h00, 8'hA0);
    total_cnt++;
    if (n_warm !== 1152) $display("FAIL nom_warmup_cycles: got %0d want 1152", n_warm); else pass_cnt++;
    total_cnt++;
    if (n_wr !== 4) $display("FAIL nom_writes: got %0d want 4", n_wr); else pass_cnt++;
    total_cnt++;
    if (n_done !== 1) $display("FAIL nom_done: got %0d want 1", n_done); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL nom_busy_end: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int w0;
    clear_mon();
    start_session(16'd8);
    load_all(8'h11, 8'h22, 1'b0);
    wait_writes(2);
    fifo_full = 1'b1;
    w0 = n_wr;
    @(negedge clk);
    total_cnt++;
    if (fifo_write !== 1'b0) $display("FAIL bp_write_while_full: got %b want 0", fifo_write); else pass_cnt++;
    tick();
    total_cnt++;
    if (core_en !== 1'b0) $display("FAIL bp_core_en: got %b want 0", core_en); else pass_cnt++;
    repeat (4) tick();
    total_cnt++;
    if (n_wr !== w0) $display("FAIL bp_no_writes: got %0d want %0d", n_wr, w0); else pass_cnt++;
    fifo_full = 1'b0;
    wait_done();
    total_cnt++;
    if (n_wr !== 8) $display("FAIL bp_writes: got %0d want 8", n_wr); else pass_cnt++;
    total_cnt++;
    if (n_done !== 1) $display("FAIL bp_done: got %0d want 1", n_done); else pass_cnt++;
`ifdef TRIV_SEQ_CNT_EN
    total_cnt++;
    if (byte_cnt !== 32'd12) $display("FAIL byte_cnt_total: got %0d want 12", byte_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_host_stall();
    clear_mon();
    start_session(16'd2);
    load_all(8'h30, 8'h40, 1'b1);
    wait_done();
    check_logs("stall", 8'h30, 8'h40);
    total_cnt++;
    if (n_wr !== 2) $display("FAIL stall_writes: got %0d want 2", n_wr); else pass_cnt++;
  endtask

  task automatic test_abort_warmup();
    clear_mon();
    start_session(16'd3);
    load_all(8'h55, 8'h66, 1'b0);
    repeat (500) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total_cnt++;
    if ({busy, core_en} !== 2'b00) $display("FAIL abort_idle: got busy,en=%b want 00", {busy, core_en}); else pass_cnt++;
    repeat (1300) tick();
    total_cnt++;
    if (n_done !== 0 || n_wr !== 0)
      $display("FAIL abort_no_done: got done=%0d writes=%0d want 0 0", n_done, n_wr);
    else pass_cnt++;
    clear_mon();
    start_session(16'd1);
    total_cnt++;
    if (host_ready !== 1'b1) $display("FAIL abort_reload_ready: got %b want 1", host_ready); else pass_cnt++;
    load_all(8'h10, 8'h20, 1'b0);
    wait_done();
    check_logs("reload", 8'h10, 8'h20);
    total_cnt++;
    if (n_warm !== 1152 || n_wr !== 1)
      $display("FAIL reload_session: got warm=%0d writes=%0d want 1152 1", n_warm, n_wr);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    start_session(16'd0);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL zero_len_start: got busy=%b want 0", busy); else pass_cnt++;
    start = 1'b1; req_len = 16'd5; abort = 1'b1;
    tick();
    start = 1'b0; req_len = '0; abort = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_start_idle: got busy=%b want 0", busy); else pass_cnt++;
    clear_mon();
    start_session(16'd4);
    host_xfer(8'h70, 1'b0);
    host_valid = 1'b0;
    start_session(16'd9);
    total_cnt++;
    if (host_ready !== 1'b1) $display("FAIL start_busy_state: got ready=%b want 1", host_ready); else pass_cnt++;
    for (int i = 1; i < 10; i++) host_xfer(8'h70 + 8'(i), 1'b0);
    for (int i = 0; i < 10; i++) host_xfer(8'h80 + 8'(i), 1'b0);
    host_valid = 1'b0;
    wait_done();
    check_logs("busy_start", 8'h70, 8'h80);
    total_cnt++;
    if (n_wr !== 4) $display("FAIL start_busy_len: got %0d want 4", n_wr); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    clear_mon();
    start_session(16'd8);
    load_all(8'h01, 8'h02, 1'b0);
    wait_writes(2);
    #1 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, host_ready, core_en, stb_key, stb_data, fifo_write, done} !== 7'b0)
      $display("FAIL async_reset_outputs: got %b want 0000000",
               {busy, host_ready, core_en, stb_key, stb_data, fifo_write, done});
    else pass_cnt++;
`ifdef TRIV_SEQ_CNT_EN
    total_cnt++;
    if (byte_cnt !== 32'd0) $display("FAIL async_reset_byte_cnt: got %0d want 0", byte_cnt); else pass_cnt++;
`endif
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({busy, host_ready, core_en} !== 3'b000)
      $display("FAIL post_reset_idle: got %b want 000", {busy, host_ready, core_en});
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; host_valid = 1'b0;
    fifo_full = 1'b0; req_len = '0; host_din = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_host_stall();
    test_abort_warmup();
    test_edges();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/trivium_seq_ctrl.md
Name: trivium_seq_ctrl

Overview:
Sequencer between the host byte interface and the Trivium keystream core plus its output FIFO. Loads key and IV bytes into the core using its key/data strobes and times the warm-up phase. It then gates keystream bytes into the FIFO under back-pressure until a requested byte count is produced. Instantiated alongside the Trivium core and the FIFO at top level; replaces direct host driving of the core strobes.

Parameters:
KEY_BYTES, 10, key bytes per session (80-bit key)
IV_BYTES, 10, IV bytes per session (80-bit IV)
WARMUP_CYC, 1152, core clock cycles discarded after load (4 x 288)
LEN_W, 16, width of requested keystream length

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle session start pulse; sampled in IDLE only
req_len  in  LEN_W  keystream bytes to produce; sampled with start
abort  in  1  return to IDLE from any state
host_din  in  8  key/IV byte from host
host_valid  in  1  host byte valid
host_ready  out  1  controller accepts a byte this cycle
core_din  out  8  byte to core din
core_stb_key  out  1  one-cycle key byte strobe to core
core_stb_data  out  1  one-cycle IV byte strobe to core
core_en  out  1  core advance enable (stall when low)
core_wt_sgn  in  1  core has a keystream byte this cycle
fifo_full  in  1  FIFO full flag
fifo_write  out  1  write strobe to FIFO
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when session completes

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; counters 0.
- States: IDLE, LOAD_KEY, LOAD_IV, WARMUP, RUN, DONE.
- IDLE: start=1 and req_len!=0 -> LOAD_KEY; latch req_len into remaining. start with req_len=0 is ignored.
- LOAD_KEY: host_ready=1. Each host_valid&host_ready registers core_din<=host_din and core_stb_key<=1 for exactly one cycle (1-cycle latency). After KEY_BYTES transfers -> LOAD_IV.
- LOAD_IV: same rules with core_stb_data. After IV_BYTES transfers -> WARMUP.
- host_ready=0 in all other states. Strobes are never asserted in back-to-back states without an intervening accepted byte.
- WARMUP: core_en=1. Counter runs 0..WARMUP_CYC-1. core_wt_sgn is ignored and fifo_write=0. On terminal count -> RUN.
- RUN: core_en = !fifo_full & (remaining!=0), registered.
- fifo_write = core_wt_sgn & (state==RUN) & !fifo_full & (remaining!=0), combinational.
- Each fifo_write decrements remaining. remaining reaching 0 -> DONE.
- core_wt_sgn while fifo_full: the byte is dropped and core_en is already low. The core must honour core_en so this cannot occur in a legal system. Verification flags it.
- DONE: done=1 for one cycle, then IDLE.
- abort=1 in any state: next state IDLE; strobes, core_en and fifo_write deassert the next cycle; done is not pulsed. abort has priority over start and over simultaneous byte transfer.
- start while busy: ignored.
- remaining uses LEN_W bits with no wrap. Decrement only when remaining!=0.

Optional Feature:
Macro TRIV_SEQ_CNT_EN.
- Defined: adds output byte_cnt [31:0], a total count of fifo_write pulses since reset that wraps at 2^32. Cleared only by rst, not by abort.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Shared package trivium_pkg: state enum type, KEY_BYTES/IV_BYTES/WARMUP_CYC defaults, byte typedef.
- One sub-module, trivium_seq_cnt: a loadable down-counter with zero flag. It is instantiated twice, once for the load/warm-up counter and once for remaining.
- FSM and gating stay in trivium_seq_ctrl.

Test Plan:
- Reset mid-RUN: drive rst=0 -> all outputs 0 asynchronously; busy=0; after release, start is required again.
- Nominal, req_len=4: 10 key bytes 0x00..0x09 -> 10 core_stb_key pulses with matching core_din. Then 10 IV bytes -> 10 core_stb_data pulses. Then exactly 1152 cycles with fifo_write=0. Then 4 fifo_write pulses, done pulse, busy=0.
- Host stalls: host_valid toggled 1/0 during LOAD_KEY -> strobe count still 10, no duplicate strobes, core_din order preserved.
- Back-pressure: fifo_full=1 for 5 cycles in RUN, req_len=8 -> core_en=0 the cycle after full, no fifo_write while full, 8 writes total.
- Abort during WARMUP at count 500 -> IDLE next cycle, done never pulsed. A new start then redoes the full key/IV load.
- Edge cases: start with req_len=0 -> stays IDLE. start while busy -> ignored. abort and start in the same cycle in IDLE -> stays IDLE. With TRIV_SEQ_CNT_EN defined, byte_cnt=12 after req_len=4 and req_len=8 sessions.
